fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter HLT_OPCODE, default 4'hF, instr[15:12] value identifying the halt instruction.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 imem_addr  output  16  instruction memory address, equal to the current PC.
REQ-006 imem_en  output  1  instruction memory read enable.
REQ-007 imem_wr  output  1  instruction memory write enable, tied 0.
REQ-008 imem_rdata  input  16  instruction word, valid combinationally in the same cycle as imem_addr/imem_en.
REQ-009 redirect_valid  input  1  branch/jump redirect request from a later stage.
REQ-010 redirect_pc  input  16  redirect target.
REQ-011 id_ready  input  1  decode accepts the IF/ID entry this cycle.
REQ-012 id_valid  output  1  IF/ID entry valid.
REQ-013 id_instr  output  16  IF/ID instruction.
REQ-014 id_pc  output  16  address of id_instr.
REQ-015 id_pc_plus2  output  16  id_pc + 2, modulo 2^16.
REQ-016 pc  output  16  current fetch PC.
REQ-017 hlt  output  1  processor halted.
REQ-018 fetch_cnt  output  16  accepted-fetch count; present only with FETCH_CNT_EN.

Function
REQ-019 States: RUN (fetching), DRAIN (halt instruction held in IF/ID, fetch stopped), HALTED (terminal until reset).
REQ-020 advance = !id_valid | id_ready; imem_en = (state==RUN) & advance & !redirect_valid.
REQ-021 RUN with imem_en: next cycle IF/ID <= {imem_rdata, pc, pc+2}, id_valid=1, pc <= pc+2; one-cycle fetch latency.
REQ-022 PC arithmetic is 16-bit unsigned with wrap: 16'hFFFE + 2 = 16'h0000.
REQ-023 Stall (id_valid & !id_ready, no redirect): pc and IF/ID hold, imem_en=0.
REQ-024 RUN, id_ready & !id_valid not required: decode accepting while fetch continues gives back-to-back one instruction per cycle.
REQ-025 Fetched imem_rdata[15:12]==HLT_OPCODE: instruction captured into IF/ID, pc not incremented, state -> DRAIN.
REQ-026 DRAIN: imem_en=0; when id_valid & id_ready: id_valid <= 0, state -> HALTED.
REQ-027 HALTED: hlt=1, imem_en=0, id_valid=0, pc frozen; redirect_valid ignored.
REQ-028 redirect_valid in RUN or DRAIN: highest priority over stall and fetch; next cycle pc = {redirect_pc[15:1],1'b0}, id_valid=0 (flush), state = RUN; no fetch that cycle.
REQ-029 Redirect and id_ready in the same cycle: IF/ID entry counts as consumed by decode, then flushed; a HLT consumed this way still enters HALTED only if no redirect (redirect wins, state -> RUN).
REQ-030 id_instr/id_pc/id_pc_plus2 hold their last values when id_valid=0.

Reset
REQ-031 rst=1 at posedge: pc=RESET_PC, state=RUN, id_valid=0, id_instr=0, id_pc=0, id_pc_plus2=0, hlt=0, fetch_cnt=0; takes precedence over all inputs, including mid-stall, DRAIN and HALTED.
REQ-032 While rst=1, imem_en=0.

Configuration
REQ-033 Macro FETCH_CNT_EN defined: fetch_cnt port exists, increments by 1 (wrapping at 16'hFFFF) on every cycle with imem_en=1.
REQ-034 FETCH_CNT_EN undefined: port and counter absent; all other behaviour identical.

Structure
REQ-035 Shared package cpu_pkg holds the fetch state enum (RUN/DRAIN/HALTED), the instruction width (16), and the PC increment constant (2).
REQ-036 One sub-module, if_id_reg: the IF/ID pipeline register with load, flush and sync reset.

Verification
REQ-037 Reset release, id_ready=1, memory word[i]=16'h1000+i: imem_addr 0,2,4,...; id_pc 0,2,4 one cycle later with matching id_instr.
REQ-038 id_ready=0 for 3 cycles with id_valid=1: pc, id_instr unchanged, imem_en=0; resume without loss or duplication.
REQ-039 redirect_valid with redirect_pc=16'h0041 during a stall: next cycle id_valid=0, pc=16'h0040; following cycle id_pc=16'h0040.
REQ-040 HLT word 16'hF000 at 16'h0006: DRAIN, then id_ready=1 -> hlt=1 next cycle, pc stays 16'h0006; later redirect ignored.
REQ-041 HLT in DRAIN with redirect to 16'h0100: state RUN, hlt stays 0, fetch resumes at 16'h0100.
REQ-042 RESET_PC=16'hFFFE: fetches FFFE then 0000; with FETCH_CNT_EN, fetch_cnt=2 after these.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: state encoding, instruction/PC widths, IF/ID entry layout.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] PC_INC = 16'd2;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [PC_W-1:0]    pc_plus2;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one-cycle capture on load, flush clears only the valid bit.
// Payload holds its last value while invalid; reset clears everything.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   flush,
    input  if_id_t entry,
    output logic   valid,
    output if_id_t data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= entry;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one-cycle fetch into IF/ID, stalls when decode holds off, halts on HLT.
// Optional FETCH_CNT_EN adds the fetch_cnt port counting issued fetches.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]      HLT_OPCODE = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_en,
    output logic               imem_wr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [PC_W-1:0]    id_pc,
    output logic [PC_W-1:0]    id_pc_plus2,
    output logic [PC_W-1:0]    pc,
    output logic               hlt
`ifdef FETCH_CNT_EN
    ,
    output logic [15:0]        fetch_cnt
`endif
);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            advance;
    logic            fetch;
    logic            load;
    logic            flush;
    if_id_t          entry_in;
    if_id_t          entry;

    assign advance   = !id_valid || id_ready;
    assign fetch     = !rst && (state == RUN) && advance && !redirect_valid;
    assign imem_en   = fetch;
    assign imem_wr   = 1'b0;
    assign imem_addr = pc;
    assign hlt       = (state == HALTED);
    assign entry_in  = '{instr: imem_rdata, pc: pc, pc_plus2: pc + PC_INC};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Redirect outranks stall and fetch; once halted only reset restarts the stage.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        load      = 1'b0;
        flush     = 1'b0;
        if (redirect_valid && state != HALTED) begin
            state_nxt = RUN;
            pc_nxt    = {redirect_pc[PC_W-1:1], 1'b0};
            flush     = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (fetch) begin
                        load = 1'b1;
                        if (imem_rdata[INSTR_W-1:INSTR_W-4] == HLT_OPCODE) begin
                            state_nxt = DRAIN;
                        end else begin
                            pc_nxt = pc + PC_INC;
                        end
                    end
                end
                DRAIN: begin
                    if (id_valid && id_ready) begin
                        flush     = 1'b1;
                        state_nxt = HALTED;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    if_id_reg u_if_id (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .flush (flush),
        .entry (entry_in),
        .valid (id_valid),
        .data  (entry)
    );

    assign id_instr    = entry.instr;
    assign id_pc       = entry.pc;
    assign id_pc_plus2 = entry.pc_plus2;

`ifdef FETCH_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
        end else if (fetch) begin
            fetch_cnt <= fetch_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: scoreboard of IF/ID entries accepted by decode plus point checks.
module tb_fetch_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, redirect_valid, id_ready;
    logic [15:0] redirect_pc, imem_rdata;
    logic [15:0] imem_addr, id_instr, id_pc, id_pc_plus2, pc;
    logic        imem_en, imem_wr, id_valid, hlt;

    logic        rst2, redirect_valid2, id_ready2;
    logic [15:0] redirect_pc2, imem_rdata2;
    logic [15:0] imem_addr2, id_instr2, id_pc2, id_pc_plus22, pc2;
    logic        imem_en2, imem_wr2, id_valid2, hlt2;
`ifdef FETCH_CNT_EN
    logic [15:0] fetch_cnt, fetch_cnt2;
`endif

    // Memory image: word i holds 16'h1000+i, except a HLT word at address 6.
    assign imem_rdata  = (imem_addr == 16'h0006) ? 16'hF000 : 16'h1000 + {1'b0, imem_addr[15:1]};
    assign imem_rdata2 = (imem_addr2 == 16'h0006) ? 16'hF000 : 16'h1000 + {1'b0, imem_addr2[15:1]};

    fetch_unit u_dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_en(imem_en), .imem_wr(imem_wr),
        .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
        .id_pc_plus2(id_pc_plus2), .pc(pc), .hlt(hlt)
`ifdef FETCH_CNT_EN
        , .fetch_cnt(fetch_cnt)
`endif
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) u_dut2 (
        .clk(clk), .rst(rst2), .imem_addr(imem_addr2), .imem_en(imem_en2), .imem_wr(imem_wr2),
        .imem_rdata(imem_rdata2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .id_ready(id_ready2), .id_valid(id_valid2), .id_instr(id_instr2), .id_pc(id_pc2),
        .id_pc_plus2(id_pc_plus22), .pc(pc2), .hlt(hlt2)
`ifdef FETCH_CNT_EN
        , .fetch_cnt(fetch_cnt2)
`endif
    );

    logic [47:0] exp_q[$];
    logic [47:0] got;
    logic [47:0] want;
    int checks = 0;
    int errors = 0;

    function automatic logic [47:0] ent(input logic [15:0] instr, input logic [15:0] p);
        return {instr, p, p + 16'd2};
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Every entry decode accepts must be the next expected one.
    always @(negedge clk) begin
        if (!rst && id_valid && id_ready) begin
            got = {id_instr, id_pc, id_pc_plus2};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL id_accept: got %h expected no entry", got);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL id_accept: got %h expected %h", got, want);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 16'h0000;
        rst2 = 1'b1; id_ready2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = 16'h0000;
        cyc(); cyc();
        chk("reset_pc", pc, 16'h0000);
        chk("reset_id_valid", id_valid, 0);
        chk("reset_hlt", hlt, 0);
        chk("reset_imem_en", imem_en, 0);
        chk("reset_id_instr", id_instr, 16'h0000);
        chk("imem_wr", imem_wr, 0);
`ifdef FETCH_CNT_EN
        chk("reset_fetch_cnt", fetch_cnt, 16'h0000);
`endif

        // Streaming fetch after reset release.
        rst = 1'b0; id_ready = 1'b1;
        exp_q.push_back(ent(16'h1000, 16'h0000));
        #1;
        chk("fetch0_addr", imem_addr, 16'h0000);
        chk("fetch0_en", imem_en, 1);
        cyc();
        exp_q.push_back(ent(16'h1001, 16'h0002));
        #1;
        chk("fetch1_addr", imem_addr, 16'h0002);
        chk("lat_id_pc", id_pc, 16'h0000);
        chk("lat_id_instr", id_instr, 16'h1000);

        // Three-cycle decode stall.
        cyc();
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stall_pc", pc, 16'h0004);
            chk("stall_instr", id_instr, 16'h1001);
            chk("stall_en", imem_en, 0);
            cyc();
        end
        id_ready = 1'b1;
        #1;
        chk("resume_addr", imem_addr, 16'h0004);
        chk("resume_en", imem_en, 1);

        // Redirect during a stall flushes the word fetched from 4.
        cyc();
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0041;
        #1;
        chk("nodup_id_pc", id_pc, 16'h0004);
        chk("redir_en", imem_en, 0);
        cyc();
        redirect_valid = 1'b0; id_ready = 1'b1;
        exp_q.push_back(ent(16'h1020, 16'h0040));
        #1;
        chk("redir_id_valid", id_valid, 0);
        chk("redir_pc", pc, 16'h0040);
        cyc();
        redirect_valid = 1'b1; redirect_pc = 16'h0006;
        #1;
        chk("redir_id_pc", id_pc, 16'h0040);
        chk("redir_accept_en", imem_en, 0);

        // HLT at 6: drain, halt, ignore redirect.
        cyc();
        redirect_valid = 1'b0;
        exp_q.push_back(ent(16'hF000, 16'h0006));
        #1;
        chk("hlt_fetch_pc", pc, 16'h0006);
        chk("hlt_fetch_en", imem_en, 1);
        cyc();
        id_ready = 1'b0;
        #1;
        chk("drain_pc", pc, 16'h0006);
        chk("drain_en", imem_en, 0);
        chk("drain_valid", id_valid, 1);
        chk("drain_hlt", hlt, 0);
        chk("drain_instr", id_instr, 16'hF000);
        cyc();
        id_ready = 1'b1;
        #1;
        chk("drain2_hlt", hlt, 0);
        cyc();
        redirect_valid = 1'b1; redirect_pc = 16'h0100;
        #1;
        chk("halt_hlt", hlt, 1);
        chk("halt_valid", id_valid, 0);
        chk("halt_pc", pc, 16'h0006);
        chk("halt_en", imem_en, 0);
        cyc();
        redirect_valid = 1'b0; id_ready = 1'b0;
        #1;
        chk("halted_hlt", hlt, 1);
        chk("halted_pc", pc, 16'h0006);
        chk("halted_valid", id_valid, 0);

        // Reset out of HALTED, then HLT in DRAIN overridden by a redirect.
        rst = 1'b1;
        cyc();
        chk("rst_halt_hlt", hlt, 0);
        chk("rst_halt_pc", pc, 16'h0000);
        rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'h0006;
        #1;
        chk("s2_redir_en", imem_en, 0);
        cyc();
        redirect_valid = 1'b0;
        exp_q.push_back(ent(16'hF000, 16'h0006));
        #1;
        chk("s2_pc", pc, 16'h0006);
        chk("s2_en", imem_en, 1);
        cyc();
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'h0100;
        #1;
        chk("s2_drain_en", imem_en, 0);
        cyc();
        redirect_valid = 1'b0;
        exp_q.push_back(ent(16'h1080, 16'h0100));
        #1;
        chk("d2r_hlt", hlt, 0);
        chk("d2r_pc", pc, 16'h0100);
        chk("d2r_valid", id_valid, 0);
        chk("d2r_en", imem_en, 1);
        cyc();
        #1;
        chk("d2r_id_pc", id_pc, 16'h0100);
        cyc();
        id_ready = 1'b0;
        #1;
        chk("d2r_id_pc2", id_pc, 16'h0102);
        rst = 1'b1;

        // RESET_PC=FFFE instance: wrap to 0000.
        rst2 = 1'b0; id_ready2 = 1'b1;
        #1;
        chk("wrap_addr0", imem_addr2, 16'hFFFE);
        chk("wrap_en0", imem_en2, 1);
        chk("wrap_wr", imem_wr2, 0);
        cyc();
        chk("wrap_id_pc", id_pc2, 16'hFFFE);
        chk("wrap_id_pc2", id_pc_plus22, 16'h0000);
        chk("wrap_id_instr", id_instr2, 16'h8FFF);
        chk("wrap_addr1", imem_addr2, 16'h0000);
        cyc();
        id_ready2 = 1'b0;
        chk("wrap2_id_pc", id_pc2, 16'h0000);
        chk("wrap2_id_instr", id_instr2, 16'h1000);
        chk("wrap2_pc", pc2, 16'h0002);
        chk("wrap2_valid", id_valid2, 1);
        chk("wrap2_hlt", hlt2, 0);
`ifdef FETCH_CNT_EN
        chk("wrap_fetch_cnt", fetch_cnt2, 16'd2);
`endif

        cyc();
        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
